// File: rtl/alu_stage_pkg.sv
// Shared types and constants for the ALU result stage: instruction kinds,
// rstatus rewrite codes and the writeback entry carried by the skid buffer.
package alu_stage_pkg;

    localparam int unsigned ENTRY_DW = 32;
    localparam int unsigned ENTRY_RW = 5;

    typedef enum logic [2:0] {
        KIND_ADD  = 3'd0,
        KIND_SUB  = 3'd1,
        KIND_ADDI = 3'd2,
        KIND_ALU  = 3'd3,
        KIND_BNE  = 3'd4,
        KIND_BLT  = 3'd5,
        KIND_NOP  = 3'd6,
        KIND_RSVD = 3'd7
    } kind_e;

    localparam int unsigned RSTATUS_REG  = 30;
    localparam int unsigned RSTATUS_ADD  = 1;
    localparam int unsigned RSTATUS_ADDI = 2;
    localparam int unsigned RSTATUS_SUB  = 3;

    typedef struct packed {
        logic [ENTRY_DW-1:0] data;
        logic [ENTRY_RW-1:0] rd;
        logic                we;
    } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus bundle for alu_result_stage: upstream ALU/metadata inputs, writeback
// handshake and branch redirect. master = environment, slave = stage.
interface alu_result_stage_if
    import alu_stage_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
);
    logic          in_valid;
    logic          in_ready;
    kind_e         in_kind;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_target;
    logic [DW-1:0] alu_result;
    logic          alu_ne;
    logic          alu_lt;
    logic          alu_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd;
    logic          out_we;
    logic          branch_taken;
    logic [DW-1:0] branch_target;

    modport master (
        output in_valid, in_kind, in_rd, in_target, alu_result,
               alu_ne, alu_lt, alu_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_we,
               branch_taken, branch_target
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_target, alu_result,
               alu_ne, alu_lt, alu_ovf, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_we,
               branch_taken, branch_target
    );
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry valid/ready FIFO of writeback entries. Head and ready are
// registered so nothing on the push side reaches the pop side combinationally.
module result_skid_fifo
    import alu_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_valid,
    input  entry_t push_entry,
    output logic   push_ready,
    output logic   pop_valid,
    input  logic   pop_ready,
    output entry_t pop_entry
);

    logic [1:0] count_q, count_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic       ready_q, ready_d;
    logic       push, pop;

    always_comb begin
        push    = push_valid && ready_q;
        pop     = (count_q != 2'd0) && pop_ready;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                // push+pop at one entry: the new entry replaces the head directly
                if (push && pop) begin
                    head_d = push_entry;
                end else if (push) begin
                    tail_d  = push_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    assign push_ready = ready_q;
    assign pop_valid  = (count_q != 2'd0);
    assign pop_entry  = head_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-memory stage: resolves bne/blt, squashes the wrong-path slot and
// buffers writebacks. Build macro OVF_RSTATUS_EN enables the overflow rewrite.
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int unsigned DW = ENTRY_DW,
    parameter int unsigned RW = ENTRY_RW
) (
    input logic               clock,
    input logic               reset,
    alu_result_stage_if.slave stg
);

`ifdef OVF_RSTATUS_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          accept, is_arith, is_wb, taken;
    logic          push_valid, push_ready, pop_valid;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_we;
    entry_t        push_entry, head;

    logic          squash_q, squash_d;
    logic          branch_taken_q, branch_taken_d;
    logic [DW-1:0] branch_target_q, branch_target_d;

    always_comb begin
        is_arith   = stg.in_kind inside {KIND_ADD, KIND_SUB, KIND_ADDI};
        is_wb      = is_arith || (stg.in_kind == KIND_ALU);
        // A squashed slot is still consumed: ready stays up, the entry is dropped
        accept     = stg.in_valid && push_ready && !squash_q;
        taken      = accept && stg.alu_ne &&
                     ((stg.in_kind == KIND_BNE) ||
                      ((stg.in_kind == KIND_BLT) && stg.alu_lt));
        push_valid = accept && is_wb;

        wb_data = stg.alu_result;
        wb_rd   = stg.in_rd;
        wb_we   = (stg.in_rd != '0);
        if (OVF_EN && is_arith && stg.alu_ovf) begin
            wb_rd = RW'(RSTATUS_REG);
            wb_we = 1'b1;
            case (stg.in_kind)
                KIND_ADD: wb_data = DW'(RSTATUS_ADD);
                KIND_SUB: wb_data = DW'(RSTATUS_SUB);
                default:  wb_data = DW'(RSTATUS_ADDI);
            endcase
        end
        push_entry = '{data: wb_data, rd: wb_rd, we: wb_we};

        squash_d        = taken;
        branch_taken_d  = taken;
        branch_target_d = taken ? stg.in_target : branch_target_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            squash_q        <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            squash_q        <= squash_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
        end
    end

    result_skid_fifo u_fifo (
        .clk        (clock),
        .rst_n      (reset),
        .push_valid (push_valid),
        .push_entry (push_entry),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_ready  (stg.out_ready),
        .pop_entry  (head)
    );

    assign stg.in_ready      = push_ready;
    assign stg.out_valid     = pop_valid;
    assign stg.out_data      = head.data;
    assign stg.out_rd        = head.rd;
    assign stg.out_we        = head.we;
    assign stg.branch_taken  = branch_taken_q;
    assign stg.branch_target = branch_target_q;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-memory stage directly downstream of the ALU.
- Captures the ALU result and flags with instruction metadata, resolves bne/blt, and applies overflow-to-rstatus rewrite.
- Presents writeback entries through a valid/ready handshake backed by a 2-entry skid buffer.
- Squashes the one wrong-path instruction that follows a taken branch.

Parameters:
- DW, 32, data width of ALU result and PC/target.
- RW, 5, register-index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered, equals (count<2).
- in_kind  in  3  instruction class (package enum).
- in_rd  in  RW  destination register.
- in_target  in  DW  precomputed branch target.
- alu_result  in  DW  ALU data_result.
- alu_ne  in  1  ALU isNotEqual.
- alu_lt  in  1  ALU isLessThan.
- alu_ovf  in  1  ALU overflow.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DW  writeback value.
- out_rd  out  RW  writeback register.
- out_we  out  1  register write enable.
- branch_taken  out  1  one-cycle redirect pulse.
- branch_target  out  DW  redirect PC, valid while branch_taken=1.

Behaviour:
- Reset (reset=0, async): count=0, in_ready=0 while asserted, then 1 on the first clock after release. Also: out_valid=0, out_data=0, out_rd=0, out_we=0, branch_taken=0, branch_target=0, squash flag=0.
- Accept occurs when in_valid & in_ready & !squash.
- Kinds: ADD=0, SUB=1, ADDI=2, ALU=3 (and/or/sll/sra), BNE=4, BLT=5, NOP=6, 7 reserved (treated as NOP).
- ADD/SUB/ADDI/ALU: enqueue {alu_result, in_rd, we=(in_rd!=0)}.
- NOP and reserved kinds: accepted, nothing enqueued.
- BNE: taken iff alu_ne=1. BLT: taken iff alu_ne=1 & alu_lt=1. Branches are never enqueued.
- Taken branch: next cycle branch_taken=1 and branch_target=in_target (registered). The squash flag is set for that same cycle.
- While squash=1, in_ready is still driven, but any in_valid entry is consumed and dropped (the wrong-path slot). squash clears after one cycle.
- Not-taken branch: no pulse, no squash.
- Latency: accept at edge N -> entry visible on out_* after edge N (1 cycle).
- Buffer: 2-entry FIFO, head drives out_*. out_* are registered from storage; no combinational path from in_* to out_*.
- Pop occurs when out_valid & out_ready.
- Simultaneous push and pop at count=1: count stays 1 and the new entry becomes head the next cycle.
- At count=2, in_ready=0. A pop frees the slot and in_ready returns to 1 the cycle after.
- With count=0 and no push, out_valid=0 and out_data/out_rd/out_we hold their last value, don't-care.
- Reset mid-operation: buffered entries discarded, a pending branch_taken is cancelled, no partial outputs.
- The alu_ovf flag is ignored for ALU/branch kinds.

Optional Feature:
- OVF_RSTATUS_EN defined: on ADD/SUB/ADDI with alu_ovf=1, the enqueued entry is rewritten to rd=30, data=1/3/2 respectively (ADD=1, ADDI=2, SUB=3), we=1.
- Undefined: alu_ovf is ignored entirely and the raw result is written to in_rd.

Decomposition:
- Package alu_stage_pkg holds:
  - kind enum constants (KIND_ADD..KIND_NOP);
  - RSTATUS_REG=30;
  - RSTATUS_ADD=1, RSTATUS_ADDI=2, RSTATUS_SUB=3;
  - the entry struct typedef {data, rd, we}.
- One sub-module: result_skid_fifo, a 2-deep valid/ready FIFO carrying the entry struct. Branch/overflow logic stays in the top.

Test Plan:
- Reset release, then ADD rd=5 result 0x0000_000A with out_ready=1 -> one cycle later out_valid=1, out_rd=5, out_data=0xA, out_we=1.
- out_ready=0, three back-to-back ADD accepts offered -> two accepted, in_ready=0 on third. Raise out_ready -> pops in order with data intact, in_ready returns to 1 after first pop.
- BLT with alu_ne=1, alu_lt=1, in_target=0x40, then ADD on following cycle -> branch_taken=1 for one cycle with branch_target=0x40. The ADD is dropped, no out_valid.
- BNE with alu_ne=0 -> no branch_taken. The next ADD is accepted normally.
- SUB rd=7, alu_ovf=1, result 0x8000_0000:
  - with OVF_RSTATUS_EN -> out_rd=30, out_data=3;
  - without OVF_RSTATUS_EN -> out_rd=7, out_data=0x8000_0000.
- Two entries buffered, reset pulsed low mid-cycle -> out_valid and branch_taken drop immediately. After release the buffer is empty and no stale entry is ever presented.
